reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//   Parametrised register file with multi-port read, same-cycle write bypass and a
//   per-register pending-write scoreboard. Successor to the fixed 4x16b two-read-port file.
//   Sits between decode and writeback of the 16-bit MIPS datapath. Multi-cycle producers
//   (loads, future mul/div) reserve a destination at issue. Readers of a pending register
//   are held via stall until writeback clears the reservation.
// PARAMETERS
//   DATA_W  16  register width in bits
//   ADDR_W  2   address width; NREGS = 2**ADDR_W; register 0 is hardwired zero
//   NRD     2   number of read ports (1..4)
//   BYPASS  1   1 = forward same-cycle write data to reads; 0 = no forwarding
// PORTS
//   clock      in   1             rising-edge clock
//   reset_n    in   1             asynchronous, active-low reset
//   rd_en      in   NRD           read port i is in use this cycle (drives stall only)
//   rd_addr    in   NRD*ADDR_W    port i address = rd_addr[i*ADDR_W +: ADDR_W]
//   rd_data    out  NRD*DATA_W    port i data    = rd_data[i*DATA_W +: DATA_W]
//   rd_busy    out  NRD           port i register is pending (after bypass)
//   stall      out  1             OR over i of (rd_en[i] & rd_busy[i])
//   wr_en      in   1             writeback strobe
//   wr_addr    in   ADDR_W        writeback register
//   wr_data    in   DATA_W        writeback value
//   rsv_en     in   1             request to reserve rsv_addr as pending destination
//   rsv_addr   in   ADDR_W        register to reserve
//   rsv_ack    out  1             reservation accepted this cycle (combinational)
//   busy_cnt   out  ADDR_W+1      number of registers currently pending
// BEHAVIOUR
//   Reset
//   - reset_n low asynchronously clears all registers and busy bits.
//   - While reset_n is low: rd_data=0, rd_busy=0, stall=0, busy_cnt=0.
//   - rsv_ack follows its combinational equation; no state updates while reset_n is low.
//   - Reset mid-reservation drops all pending state. Producers are reset by the same reset_n.
//   Write
//   - At a rising edge with wr_en=1 and wr_addr!=0: reg[wr_addr] <= wr_data.
//   - Writes to r0 are discarded.
//   - A write to a non-busy register is legal and updates data.
//   Read
//   - Combinational, zero latency. Address 0 always returns 0.
//   - BYPASS=1, wr_en=1, wr_addr==rd_addr[i]!=0: rd_data[i]=wr_data in the same cycle.
//   - Otherwise rd_data[i] returns the stored value.
//   - Any number of ports may read the same address.
//   Scoreboard (busy[NREGS-1:1]; busy[0] is constant 0)
//   - hit_w(r) = wr_en & (wr_addr==r).
//   - rd_busy[i] = busy[rd_addr[i]] & ~(BYPASS & hit_w(rd_addr[i])).
//   - rsv_ack = rsv_en & ((rsv_addr==0) | ~busy[rsv_addr] | hit_w(rsv_addr)).
//     This refuses a WAW reservation unless the old value is retiring this cycle.
//   - Edge update, applied in order (later rule overrides earlier):
//     (1) hit_w(r) clears busy[r];
//     (2) rsv_ack & rsv_addr==r!=0 sets busy[r].
//     Simultaneous write and reserve to the same register leaves it busy (new pending producer).
//   - Reserving r0: rsv_ack=1, no state change.
//   - rsv_en=1 with rsv_ack=0 changes nothing. The requester holds rsv_en and retries.
//   - busy_cnt = popcount(busy). Range 0..NREGS-1; it never wraps.
//   - stall is purely combinational. It does not gate writes or reservations.
// TESTING
//   1 Reset: load r1..r3, pulse reset_n low mid-cycle.
//     -> all rd_data=0 and busy_cnt=0 immediately, with no clock edge.
//   2 Write/read: wr r1=15, r2=7; rd_addr={2,1}.
//     -> rd_data={7,15}. Write r0=0xFFFF -> rd r0=0.
//   3 Bypass: r3=0; same cycle wr_en r3=22 and rd_addr0=3.
//     -> BYPASS=1: rd_data0=22, rd_busy0=0. BYPASS=0: rd_data0=0.
//   4 Scoreboard: rsv r2 -> rsv_ack=1; next cycle rd_en0=1, rd_addr0=2.
//     -> rd_busy0=1, stall=1, busy_cnt=1.
//     Then wr r2=8 -> same cycle stall=0, rd_data0=8 (BYPASS=1); next cycle busy_cnt=0.
//   5 WAW: r1 busy, rsv r1 alone -> rsv_ack=0 and busy unchanged.
//     rsv r1 with wr r1=5 same cycle -> rsv_ack=1; r1=5, r1 still busy, busy_cnt=1.
//   6 Params: ADDR_W=3, NRD=3, DATA_W=32.
//     Reserve r1..r7 -> busy_cnt=7. All three ports read r7=0xDEADBEEF after its write.

Source files
------------

// File: rtl/reg_file_sb.sv
// Parametrised register file with combinational multi-port read, same-cycle write bypass
// and a per-register pending-write scoreboard used to stall readers of in-flight results.
module reg_file_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2,
    parameter int NRD    = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NRD-1:0]          rd_en,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    output logic                    stall,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic                    rsv_ack,
    output logic [ADDR_W:0]         busy_cnt
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    // A reservation on a busy register is only accepted when its old producer retires now.
    assign rsv_ack = rsv_en & ((rsv_addr == '0) | ~busy_q[rsv_addr] |
                               (wr_en & (wr_addr == rsv_addr)));

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        busy_d = busy_q;
        if (wr_en && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
        // Set after clear: a simultaneous retire and re-reserve leaves the register pending.
        for (int r = 1; r < NREGS; r++) begin
            if (wr_en && (wr_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (rsv_ack && (rsv_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic              hit;
        rd_data = '0;
        rd_busy = '0;
        stall   = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra  = rd_addr[i*ADDR_W +: ADDR_W];
            hit = BYPASS && wr_en && (wr_addr == ra);
            // Outputs are forced quiet while reset is held, even if a bypass would apply.
            if (reset_n && (ra != '0)) begin
                rd_data[i*DATA_W +: DATA_W] = hit ? wr_data : regs_q[ra];
                rd_busy[i]                  = busy_q[ra] & ~hit;
            end
            stall = stall | (rd_en[i] & rd_busy[i]);
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy_cnt = busy_cnt + (ADDR_W + 1)'(busy_q[r]);
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a behavioural register/scoreboard model.
module tb_reg_file_sb;

    localparam int AW = 2;
    localparam int DW = 16;
    localparam int NR = 2;

    localparam int BAW = 3;
    localparam int BDW = 32;
    localparam int BNR = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [NR-1:0]    rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             stall;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic             rsv_ack;
    logic [AW:0]      busy_cnt;

    logic [BNR-1:0]     b_rd_en;
    logic [BNR*BAW-1:0] b_rd_addr;
    logic [BNR*BDW-1:0] b_rd_data;
    logic [BNR-1:0]     b_rd_busy;
    logic               b_stall;
    logic               b_wr_en;
    logic [BAW-1:0]     b_wr_addr;
    logic [BDW-1:0]     b_wr_data;
    logic               b_rsv_en;
    logic [BAW-1:0]     b_rsv_addr;
    logic               b_rsv_ack;
    logic [BAW:0]       b_busy_cnt;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(1'b1)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(rsv_ack), .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.DATA_W(BDW), .ADDR_W(BAW), .NRD(BNR), .BYPASS(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .stall(b_stall), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .rsv_ack(b_rsv_ack), .busy_cnt(b_busy_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the default-parameter file: register values and pending set.
    logic [DW-1:0] mreg [4];
    logic [3:0]    mbusy;

    function automatic logic m_ack();
        return rsv_en && ((rsv_addr == 0) || !mbusy[rsv_addr] ||
                          (wr_en && (wr_addr == rsv_addr)));
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 4; r++) mreg[r] <= '0;
            mbusy <= '0;
        end else begin
            if (wr_en && wr_addr != 0) mreg[wr_addr] <= wr_data;
            for (int r = 1; r < 4; r++) begin
                if (m_ack() && rsv_addr == r) mbusy[r] <= 1'b1;
                else if (wr_en && wr_addr == r) mbusy[r] <= 1'b0;
            end
        end
    end

    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          eb;
    logic          es;

    always @(negedge clock) begin
        es = 1'b0;
        for (int i = 0; i < NR; i++) begin
            ea = rd_addr[i*AW +: AW];
            if (!reset_n || ea == 0) ed = '0;
            else if (wr_en && wr_addr == ea) ed = wr_data;
            else ed = mreg[ea];
            eb = reset_n && mbusy[ea] && !(wr_en && wr_addr == ea);
            es = es | (rd_en[i] & eb);
            chk($sformatf("m_rd_data%0d", i), 64'(rd_data[i*DW +: DW]), 64'(ed));
            chk($sformatf("m_rd_busy%0d", i), 64'(rd_busy[i]), 64'(eb));
        end
        chk("m_stall", 64'(stall), 64'(es));
        chk("m_rsv_ack", 64'(rsv_ack), 64'(m_ack()));
        chk("m_busy_cnt", 64'(busy_cnt), 64'($countones(mbusy)));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic b_idle();
        b_rd_en = '0; b_rd_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_rsv_en = 1'b0; b_rsv_addr = '0;
    endtask

    initial begin
        idle();
        b_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy_cnt", 64'(busy_cnt), 64'd0);
        chk("rst_b_busy_cnt", 64'(b_busy_cnt), 64'd0);
        reset_n = 1'b1;

        // Reset mid-cycle after loading r1..r3 and reserving r3
        tick(); wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h1111;
        tick(); wr_addr = 2'd2; wr_data = 16'h2222;
        tick(); wr_addr = 2'd3; wr_data = 16'h3333; rsv_en = 1'b1; rsv_addr = 2'd3;
        tick(); idle(); rd_addr = {2'd2, 2'd1};
        #1;
        chk("t1_pre_rd", 64'(rd_data), 64'h2222_1111);
        chk("t1_pre_cnt", 64'(busy_cnt), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t1_rst_rd", 64'(rd_data), 64'd0);
        chk("t1_rst_cnt", 64'(busy_cnt), 64'd0);
        chk("t1_rst_stall", 64'(stall), 64'd0);
        reset_n = 1'b1;

        // Write / read, and r0 discards writes
        tick(); wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'd15;
        tick(); wr_addr = 2'd2; wr_data = 16'd7;
        tick(); wr_addr = 2'd0; wr_data = 16'hFFFF; rd_addr = {2'd2, 2'd1};
        #1;
        chk("t2_rd", 64'(rd_data), {32'd0, 16'd7, 16'd15});
        tick(); idle(); rd_addr = {2'd2, 2'd0};
        #1;
        chk("t2_r0", 64'(rd_data[DW-1:0]), 64'd0);

        // Same-cycle bypass
        tick(); wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'd0;
        tick(); wr_data = 16'd22; rd_addr = {2'd0, 2'd3};
        #1;
        chk("t3_byp_data", 64'(rd_data[DW-1:0]), 64'd22);
        chk("t3_byp_busy", 64'(rd_busy[0]), 64'd0);

        // Scoreboard reserve, stall and retire
        tick(); idle(); rsv_en = 1'b1; rsv_addr = 2'd2;
        #1;
        chk("t4_ack", 64'(rsv_ack), 64'd1);
        tick(); idle(); rd_en = 2'b01; rd_addr = {2'd0, 2'd2};
        #1;
        chk("t4_rd_busy", 64'(rd_busy[0]), 64'd1);
        chk("t4_stall", 64'(stall), 64'd1);
        chk("t4_cnt", 64'(busy_cnt), 64'd1);
        tick(); wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'd8;
        #1;
        chk("t4_wb_stall", 64'(stall), 64'd0);
        chk("t4_wb_data", 64'(rd_data[DW-1:0]), 64'd8);
        tick(); idle();
        #1;
        chk("t4_cnt_after", 64'(busy_cnt), 64'd0);

        // WAW refusal and retire-with-rereserve
        tick(); rsv_en = 1'b1; rsv_addr = 2'd1;
        tick(); rsv_en = 1'b1; rsv_addr = 2'd1;
        #1;
        chk("t5_waw_ack", 64'(rsv_ack), 64'd0);
        chk("t5_waw_cnt", 64'(busy_cnt), 64'd1);
        tick(); wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'd5;
        #1;
        chk("t5_rerv_ack", 64'(rsv_ack), 64'd1);
        tick(); idle(); rd_addr = {2'd0, 2'd1};
        #1;
        chk("t5_data", 64'(rd_data[DW-1:0]), 64'd5);
        chk("t5_busy", 64'(rd_busy[0]), 64'd1);
        chk("t5_cnt", 64'(busy_cnt), 64'd1);
        tick(); wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'd6;
        tick(); idle();

        // Wide configuration without bypass
        for (int r = 1; r < 8; r++) begin
            tick(); b_rsv_en = 1'b1; b_rsv_addr = BAW'(r);
        end
        tick(); b_idle();
        #1;
        chk("t6_cnt7", 64'(b_busy_cnt), 64'd7);
        tick(); b_wr_en = 1'b1; b_wr_addr = 3'd7; b_wr_data = 32'hDEADBEEF;
        b_rd_addr = {3'd7, 3'd7, 3'd7}; b_rd_en = 3'b111;
        #1;
        chk("t6_nobyp_data", 64'(b_rd_data[BDW-1:0]), 64'd0);
        chk("t6_nobyp_busy", 64'(b_rd_busy), 64'b111);
        chk("t6_nobyp_stall", 64'(b_stall), 64'd1);
        tick(); b_wr_en = 1'b0;
        #1;
        for (int i = 0; i < BNR; i++) begin
            chk($sformatf("t6_rd%0d", i), 64'(b_rd_data[i*BDW +: BDW]), 64'hDEADBEEF);
        end
        chk("t6_busy_after", 64'(b_rd_busy), 64'd0);
        chk("t6_cnt6", 64'(b_busy_cnt), 64'd6);
        tick(); b_idle();

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 600; n++) begin
            tick();
            rd_en    = NR'($urandom);
            rd_addr  = (NR*AW)'($urandom);
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = AW'($urandom);
            wr_data  = DW'($urandom);
            rsv_en   = ($urandom_range(0, 1) == 0);
            rsv_addr = AW'($urandom);
            if ($urandom_range(0, 80) == 0) begin
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
            end
        end
        tick(); idle();
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
